// File: rtl/aurora_tx_arbiter_pkg.sv
// ------------------------------------------------------------------------
// auroraTxArbPkg: shared types, widths and round-robin helper. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

package auroraTxArbPkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_TERM = 2'd2,
      ST_DROP = 2'd3
   } arbState_e;

   localparam logic [31:0] FILLER_DEFAULT = 32'hDEAD_BEEF;
   localparam int          DATA_W         = 32;
   localparam int          MAX_PORTS      = 8;
   localparam int          GRANT_W        = 3;
   localparam int          DROP_CNT_W     = 16;

   // First requester after 'last', wrapping at numPorts; returns 'last' if none.
   function automatic logic [GRANT_W-1:0] rrNext(
      input logic [MAX_PORTS-1:0] req,
      input logic [GRANT_W-1:0]   last,
      input int                   numPorts
   );
      logic [GRANT_W-1:0] cand;
      logic [GRANT_W-1:0] pick;
      logic               found;
      cand  = last;
      pick  = last;
      found = 1'b0;
      for (int i = 1; i <= MAX_PORTS; i++) begin
         if (i <= numPorts) begin
            cand = (cand == GRANT_W'(numPorts - 1)) ? '0 : cand + GRANT_W'(1);
            if (req[cand] && !found) begin
               pick  = cand;
               found = 1'b1;
            end
         end
      end
      return pick;
   endfunction

endpackage

`default_nettype wire

// File: rtl/aurora_tx_arbiter_skid.sv
// ------------------------------------------------------------------------
// axisSkidBuffer: 2-entry AXI-stream skid buffer, registered ready/outputs. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module axisSkidBuffer #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rstN,
   input  logic              sValid_i,
   output logic              sReady_o,
   input  logic [DATA_W-1:0] sData_i,
   input  logic              sLast_i,
   output logic              mValid_o,
   input  logic              mReady_i,
   output logic [DATA_W-1:0] mData_o,
   output logic              mLast_o
);

   logic              outValid_q, outValid_d;
   logic [DATA_W-1:0] outData_q,  outData_d;
   logic              outLast_q,  outLast_d;
   logic              skValid_q,  skValid_d;
   logic [DATA_W-1:0] skData_q,   skData_d;
   logic              skLast_q,   skLast_d;
   logic              ready_q,    ready_d;
   logic              w_inFire;

   assign w_inFire = sValid_i & ready_q;

   // ready_q is low whenever the skid entry is occupied, so an input beat and
   // a skid-to-output move never coincide.
   always_comb begin
      outValid_d = outValid_q;
      outData_d  = outData_q;
      outLast_d  = outLast_q;
      skValid_d  = skValid_q;
      skData_d   = skData_q;
      skLast_d   = skLast_q;
      if (!outValid_q || mReady_i) begin
         if (skValid_q) begin
            outValid_d = 1'b1;
            outData_d  = skData_q;
            outLast_d  = skLast_q;
            skValid_d  = 1'b0;
         end else if (w_inFire) begin
            outValid_d = 1'b1;
            outData_d  = sData_i;
            outLast_d  = sLast_i;
         end else begin
            outValid_d = 1'b0;
         end
      end else if (w_inFire) begin
         skValid_d = 1'b1;
         skData_d  = sData_i;
         skLast_d  = sLast_i;
      end
      ready_d = ~skValid_d;
   end

   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         outValid_q <= 1'b0;
         outData_q  <= '0;
         outLast_q  <= 1'b0;
         skValid_q  <= 1'b0;
         skData_q   <= '0;
         skLast_q   <= 1'b0;
         ready_q    <= 1'b0;
      end else begin
         outValid_q <= outValid_d;
         outData_q  <= outData_d;
         outLast_q  <= outLast_d;
         skValid_q  <= skValid_d;
         skData_q   <= skData_d;
         skLast_q   <= skLast_d;
         ready_q    <= ready_d;
      end
   end

   assign sReady_o = ready_q;
   assign mValid_o = outValid_q;
   assign mData_o  = outData_q;
   assign mLast_o  = outLast_q;

endmodule

`default_nettype wire

// File: rtl/aurora_tx_arbiter.sv
// ------------------------------------------------------------------------
// aurora_tx_arbiter: packet-level round-robin arbiter onto the Aurora TX stream. Rev 1.0
// ------------------------------------------------------------------------
`default_nettype none

module aurora_tx_arbiter
   import auroraTxArbPkg::*;
#(
   parameter int          NUM_PORTS      = 4,
   parameter int          TIMEOUT_CYCLES = 1024,
   parameter logic [31:0] FILLER_WORD    = FILLER_DEFAULT
) (
   input  logic                        auUserClk,
   input  logic                        resetN,
   input  logic                        channelUp,
   input  logic [DATA_W*NUM_PORTS-1:0] sTdata,
   input  logic [NUM_PORTS-1:0]        sTlast,
   input  logic [NUM_PORTS-1:0]        sTvalid,
   output logic [NUM_PORTS-1:0]        sTready,
   output logic [DATA_W-1:0]           mTdata,
   output logic                        mTlast,
   output logic                        mTvalid,
   input  logic                        mTready,
   output logic [GRANT_W-1:0]          grantIdx,
   output logic                        busy,
   output logic [DROP_CNT_W-1:0]       dropCount,
   output logic                        timeoutErr,
   input  logic                        clearErr
);

   localparam int WD_W = $clog2(TIMEOUT_CYCLES);

   arbState_e             state_q,      state_d;
   logic [GRANT_W-1:0]    grantIdx_q,   grantIdx_d;
   logic [GRANT_W-1:0]    lastGrant_q,  lastGrant_d;
   logic [WD_W-1:0]       wd_q,         wd_d;
   logic [DROP_CNT_W-1:0] dropCount_q,  dropCount_d;
   logic                  timeoutErr_q, timeoutErr_d;

   logic [MAX_PORTS-1:0]  w_validPad;
   logic [MAX_PORTS-1:0]  w_lastPad;
   logic [DATA_W-1:0]     w_selData;
   logic                  w_selValid;
   logic                  w_selLast;
   logic                  w_portReady;
   logic                  w_skValid;
   logic                  w_skReady;
   logic [DATA_W-1:0]     w_skData;
   logic                  w_skLast;

   always_comb begin
      w_validPad                = '0;
      w_lastPad                 = '0;
      w_selData                 = '0;
      w_validPad[NUM_PORTS-1:0] = sTvalid;
      w_lastPad[NUM_PORTS-1:0]  = sTlast;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (grantIdx_q == GRANT_W'(p)) begin
            w_selData = sTdata[DATA_W*p +: DATA_W];
         end
      end
   end

   assign w_selValid = w_validPad[grantIdx_q];
   assign w_selLast  = w_lastPad[grantIdx_q];

   always_comb begin
      sTready = '0;
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (grantIdx_q == GRANT_W'(p)) begin
            sTready[p] = w_portReady;
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      grantIdx_d   = grantIdx_q;
      lastGrant_d  = lastGrant_q;
      wd_d         = wd_q;
      dropCount_d  = dropCount_q;
      timeoutErr_d = timeoutErr_q;
      w_portReady  = 1'b0;
      w_skValid    = 1'b0;
      w_skData     = w_selData;
      w_skLast     = w_selLast;
      unique case (state_q)
         ST_IDLE: begin
            if (channelUp && (|w_validPad)) begin
               grantIdx_d = rrNext(w_validPad, lastGrant_q, NUM_PORTS);
               wd_d       = '0;
               state_d    = ST_PASS;
            end
         end
         ST_PASS: begin
            w_portReady = w_skReady;
            w_skValid   = w_selValid;
            // A completing beat wins over link-down and the watchdog.
            if (w_selValid && w_skReady && w_selLast) begin
               lastGrant_d = grantIdx_q;
               state_d     = ST_IDLE;
            end else if (!channelUp) begin
               state_d = ST_DROP;
            end else if (!w_selValid) begin
               if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
                  state_d = ST_TERM;
               end else begin
                  wd_d = wd_q + WD_W'(1);
               end
            end else begin
               wd_d = '0;
            end
         end
         ST_TERM: begin
            w_skValid = 1'b1;
            w_skData  = FILLER_WORD;
            w_skLast  = 1'b1;
            if (w_skReady) begin
               timeoutErr_d = 1'b1;
               state_d      = ST_DROP;
            end
         end
         ST_DROP: begin
            w_portReady = 1'b1;
            if (w_selValid && w_selLast) begin
               if (dropCount_q != '1) begin
                  dropCount_d = dropCount_q + DROP_CNT_W'(1);
               end
               lastGrant_d = grantIdx_q;
               state_d     = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (clearErr) begin
         timeoutErr_d = 1'b0;
         dropCount_d  = '0;
      end
   end

   always_ff @(posedge auUserClk or negedge resetN) begin
      if (!resetN) begin
         state_q      <= ST_IDLE;
         grantIdx_q   <= '0;
         lastGrant_q  <= GRANT_W'(NUM_PORTS - 1);
         wd_q         <= '0;
         dropCount_q  <= '0;
         timeoutErr_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         grantIdx_q   <= grantIdx_d;
         lastGrant_q  <= lastGrant_d;
         wd_q         <= wd_d;
         dropCount_q  <= dropCount_d;
         timeoutErr_q <= timeoutErr_d;
      end
   end

   axisSkidBuffer #(
      .DATA_W (DATA_W)
   ) u_skid (
      .clk      (auUserClk),
      .rstN     (resetN),
      .sValid_i (w_skValid),
      .sReady_o (w_skReady),
      .sData_i  (w_skData),
      .sLast_i  (w_skLast),
      .mValid_o (mTvalid),
      .mReady_i (mTready),
      .mData_o  (mTdata),
      .mLast_o  (mTlast)
   );

   assign grantIdx   = grantIdx_q;
   assign busy       = (state_q != ST_IDLE);
   assign dropCount  = dropCount_q;
   assign timeoutErr = timeoutErr_q;

endmodule

`default_nettype wire
